// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with start/ready/valid handshake
// Shifts step one bit per cycle; mul is an N-iteration shift-add.
module alu_seq #(
  parameter int N = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [2:0]   i_control,
  output logic         o_ready,
  output logic         o_valid,
  output logic [N-1:0] q,
  output logic         carry,
  output logic         overflow,
  output logic         zero,
  output logic         negative
);
  localparam int SH_W = $clog2(N);
  localparam logic [SH_W-1:0] CNT_ONE = SH_W'(1);
  localparam logic [SH_W-1:0] CNT_MUL = SH_W'(N - 1);

  typedef enum logic {IDLE, BUSY} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SHR = 3'b001, OP_SUB = 3'b010, OP_SHL = 3'b011,
    OP_PASS = 3'b100, OP_AND = 3'b101, OP_OR = 3'b110, OP_MUL = 3'b111
  } op_e;

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [2*N-1:0]  work_q, work_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [N-1:0]    mplr_q, mplr_d;
  logic [SH_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]    res_q, res_d;
  logic            carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;
  logic            valid_q, valid_d;

  logic            done;
  logic [N-1:0]    res;
  logic            res_c, res_v;
  logic [N:0]      sum_ext, diff_ext;
  logic [SH_W-1:0] k;
  logic [N-1:0]    sh_cur;
  logic [2*N-1:0]  acc_n;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    acc_d    = acc_q;
    mplr_d   = mplr_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    valid_d  = 1'b0;
    done     = 1'b0;
    res      = '0;
    res_c    = 1'b0;
    res_v    = 1'b0;
    sum_ext  = {1'b0, i_a} + {1'b0, i_b};
    diff_ext = {1'b0, i_a} - {1'b0, i_b};
    k        = i_b[SH_W-1:0];
    sh_cur   = work_q[N-1:0];
    acc_n    = acc_q + (mplr_q[0] ? work_q : '0);

    case (state_q)
      IDLE: begin
        if (i_start) begin
          case (op_e'(i_control))
            OP_ADD: begin
              done  = 1'b1;
              res   = sum_ext[N-1:0];
              res_c = sum_ext[N];
              res_v = (i_a[N-1] == i_b[N-1]) && (sum_ext[N-1] != i_a[N-1]);
            end
            OP_SUB: begin
              done  = 1'b1;
              res   = diff_ext[N-1:0];
              res_c = diff_ext[N];
              res_v = (i_a[N-1] != i_b[N-1]) && (diff_ext[N-1] != i_a[N-1]);
            end
            OP_PASS: begin
              done = 1'b1;
              res  = i_b;
            end
            OP_AND: begin
              done = 1'b1;
              res  = i_a & i_b;
            end
            OP_OR: begin
              done = 1'b1;
              res  = i_a | i_b;
            end
            OP_SHR, OP_SHL: begin
              // The accept edge already performs the first bit of the shift.
              if (k == '0) begin
                done = 1'b1;
                res  = i_a;
              end else if (k == CNT_ONE) begin
                done  = 1'b1;
                res   = (i_control == OP_SHR) ? {1'b0, i_a[N-1:1]} : {i_a[N-2:0], 1'b0};
                res_c = (i_control == OP_SHR) ? i_a[0] : i_a[N-1];
              end else begin
                state_d = BUSY;
                op_d    = op_e'(i_control);
                cnt_d   = k - CNT_ONE;
                work_d  = {{N{1'b0}},
                           (i_control == OP_SHR) ? {1'b0, i_a[N-1:1]} : {i_a[N-2:0], 1'b0}};
              end
            end
            OP_MUL: begin
              state_d = BUSY;
              op_d    = OP_MUL;
              cnt_d   = CNT_MUL;
              acc_d   = i_b[0] ? {{N{1'b0}}, i_a} : '0;
              work_d  = {{(N-1){1'b0}}, i_a, 1'b0};
              mplr_d  = i_b >> 1;
            end
            default: ;
          endcase
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        case (op_q)
          OP_SHR, OP_SHL: begin
            res    = (op_q == OP_SHR) ? {1'b0, sh_cur[N-1:1]} : {sh_cur[N-2:0], 1'b0};
            res_c  = (op_q == OP_SHR) ? sh_cur[0] : sh_cur[N-1];
            work_d = {{N{1'b0}}, res};
          end
          OP_MUL: begin
            acc_d  = acc_n;
            work_d = work_q << 1;
            mplr_d = mplr_q >> 1;
            res    = acc_n[N-1:0];
            res_c  = |acc_n[2*N-1:N];
          end
          default: ;
        endcase
        if (cnt_q == CNT_ONE) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      res_d   = res;
      carry_d = res_c;
      ovf_d   = res_v;
      zero_d  = (res == '0);
      neg_d   = res[N-1];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      work_q  <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      valid_q <= valid_d;
    end
  end

  assign o_ready  = (state_q == IDLE);
  assign o_valid  = valid_q;
  assign q        = res_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign negative = neg_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed vector bench for alu_seq
// Table of single ops plus hand sequences for handshake and reset corners.
module tb_alu_seq;
  localparam int N = 16;

  logic         i_clk = 1'b0;
  logic         i_reset, i_start;
  logic [N-1:0] i_a, i_b;
  logic [2:0]   i_control;
  logic         o_ready, o_valid, carry, overflow, zero, negative;
  logic [N-1:0] q;

  int checks = 0;
  int errors = 0;

  alu_seq #(.N(N)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_a(i_a), .i_b(i_b),
    .i_control(i_control), .o_ready(o_ready), .o_valid(o_valid), .q(q),
    .carry(carry), .overflow(overflow), .zero(zero), .negative(negative)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [2:0]   op;
    logic [N-1:0] a, b, eq;
    logic         ec, ev, ez, en;
    int           lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat, rl;
    @(negedge i_clk);
    i_start = 1'b1; i_control = v.op; i_a = v.a; i_b = v.b;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_a = ~v.a; i_b = ~v.b;
    lat = 1; rl = 0;
    while (!o_valid && lat < 40) begin
      if (!o_ready) rl++;
      @(posedge i_clk); #1;
      lat++;
    end
    check($sformatf("v%0d latency", idx), lat, v.lat);
    check($sformatf("v%0d ready_low", idx), rl, v.lat - 1);
    check($sformatf("v%0d q", idx), q, v.eq);
    check($sformatf("v%0d flags cvzn", idx), {carry, overflow, zero, negative},
          {v.ec, v.ev, v.ez, v.en});
    check($sformatf("v%0d ready_at_valid", idx), o_ready, 1'b1);
    @(posedge i_clk); #1;
    check($sformatf("v%0d valid_pulse", idx), o_valid, 1'b0);
  endtask

  initial begin
    int nval;
    logic [N-1:0] cap_q;
    logic cap_c;
    //                 op      a        b        q        c     v     z     n    lat
    vecs[0]  = '{3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[1]  = '{3'b000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    vecs[2]  = '{3'b010, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1, 1};
    vecs[3]  = '{3'b010, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[4]  = '{3'b011, 16'h8001, 16'h0003, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0, 3};
    vecs[5]  = '{3'b001, 16'h0005, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[6]  = '{3'b011, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{3'b111, 16'h012C, 16'h012C, 16'h5F90, 1'b1, 1'b0, 1'b0, 1'b0, 16};
    vecs[8]  = '{3'b100, 16'h0000, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    vecs[9]  = '{3'b110, 16'h00F0, 16'h000F, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{3'b101, 16'h0F0F, 16'h00FF, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[11] = '{3'b001, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 15};
    vecs[12] = '{3'b111, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 16};
    vecs[13] = '{3'b111, 16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 16};

    i_reset = 1'b1; i_start = 1'b0; i_a = '0; i_b = '0; i_control = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset ready", o_ready, 1'b1);
    check("reset valid", o_valid, 1'b0);
    check("reset q", q, 16'h0000);
    check("reset flags", {carry, overflow, zero, negative}, 4'b0000);
    i_reset = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // back-to-back adds on consecutive edges
    @(negedge i_clk);
    i_start = 1'b1; i_control = 3'b000; i_a = 16'hFFFF; i_b = 16'h0001;
    @(posedge i_clk); #1;
    check("b2b add1 valid", o_valid, 1'b1);
    check("b2b add1 q/c", {carry, q}, {1'b1, 16'h0000});
    i_a = 16'h7FFF; i_b = 16'h0001;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    check("b2b add2 valid", o_valid, 1'b1);
    check("b2b add2 q/vn", {overflow, negative, q}, {1'b1, 1'b1, 16'h8000});

    // or accepted in the cycle a shl k=2 completes
    @(negedge i_clk);
    i_start = 1'b1; i_control = 3'b011; i_a = 16'h0001; i_b = 16'h0002;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    check("shl2 busy", {o_ready, o_valid}, 2'b00);
    @(posedge i_clk); #1;
    check("shl2 valid", {o_ready, o_valid}, 2'b11);
    check("shl2 q", q, 16'h0004);
    i_start = 1'b1; i_control = 3'b110; i_a = 16'h00F0; i_b = 16'h000F;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    check("or after shl valid", o_valid, 1'b1);
    check("or after shl q", q, 16'h00FF);

    // mul with a stray start while busy
    @(negedge i_clk);
    i_start = 1'b1; i_control = 3'b111; i_a = 16'h012C; i_b = 16'h012C;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (3) begin @(posedge i_clk); #1; end
    i_start = 1'b1; i_control = 3'b000; i_a = 16'h0001; i_b = 16'h0001;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    nval = 0; cap_q = '0; cap_c = 1'b0;
    repeat (30) begin
      if (o_valid) begin nval++; cap_q = q; cap_c = carry; end
      @(posedge i_clk); #1;
    end
    check("mul ignore count", nval, 1);
    check("mul ignore q/c", {cap_c, cap_q}, {1'b1, 16'h5F90});

    // reset aborts an in-flight mul
    @(negedge i_clk);
    i_start = 1'b1; i_control = 3'b111; i_a = 16'h00FF; i_b = 16'h00FF;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (4) begin @(posedge i_clk); #1; end
    check("abort busy before reset", o_ready, 1'b0);
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    check("abort ready", o_ready, 1'b1);
    check("abort q", q, 16'h0000);
    check("abort flags", {carry, overflow, zero, negative}, 4'b0000);
    nval = 0;
    repeat (20) begin
      if (o_valid) nval++;
      @(posedge i_clk); #1;
    end
    check("abort no valid", nval, 0);
    run_vec(vecs[10], 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
